prog_clock_divider: RTL and testbench
=====================================

// Module: prog_clock_divider
// PURPOSE
//  Runtime-programmable clock divider / tick generator, successor to the fixed power-of-two divider.
//  Divides clock_in by any integer period (2..2^WIDTH-1) with programmable high time.
//  Emits a divided clock_out plus a one-cycle tick at each period start.
//  Sits between the board clock and slow FSM/display logic that needs adjustable rates.
//  clock_out is a registered logic signal, not a clock-tree net; consumers sample it or use tick as an enable.
// PARAMETERS
//  WIDTH      18             width of period/high-time registers and phase counter
//  DIV_RESET  2**(WIDTH-1)   period after reset (high time = DIV_RESET>>1)
// PORTS
//  clock_in   in   1      sole clock, rising edge
//  reset_n    in   1      synchronous, active-low reset
//  enable     in   1      1 = run, 0 = park counter, outputs low
//  load       in   1      1-cycle strobe: capture div_in/duty_in
//  div_in     in   WIDTH  requested period in clock_in cycles
//  duty_in    in   WIDTH  requested high time in cycles (0 = 50%)
//  clock_out  out  1      divided clock, registered
//  tick       out  1      1-cycle pulse on first cycle of each period, registered
//  pending    out  1      1 while a loaded setting awaits application
// BEHAVIOUR
//  Interface: one clock (clock_in); reset_n synchronous, active-low. No async paths.
//  Reset (reset_n=0 at edge; overrides load and enable):
//   - phase=period-1, period=DIV_RESET, high=DIV_RESET>>1.
//   - clock_out=0, tick=0, pending=0; shadow regs discarded.
//  Clamping (applied on capture, into shadow regs):
//   - period = max(div_in,2).
//   - duty_in=0 -> high=period>>1.
//   - duty_in>=period -> high=period-1; else high=duty_in.
//  Enabled edge (enable=1):
//   - phase_n = (phase==period-1) ? 0 : phase+1.
//   - clock_out <= (phase_n < high); tick <= (phase_n==0).
//   - Output latency: a period starts on the edge where phase wraps to 0.
//   - After reset or re-enable, the first enabled edge wraps: tick=1, clock_out=1.
//  Disabled edge (enable=0):
//   - phase <= period-1; clock_out <= 0; tick <= 0.
//   - Any pending setting applies on this edge.
//  Load/update rules:
//   - load=1 captures clamped values into shadow regs and sets pending.
//   - A later load before application overwrites the shadow (last wins).
//   - Shadow -> active on the wrap edge (phase==period-1, enable=1) or any disabled edge; pending clears then.
//   - On that wrap edge, the new high applies to phase_n=0 (no runt or stretched pulse).
//   - load on the same edge as a wrap applies immediately; pending stays 0.
//   - load with enable=0 applies on that edge.
//   - Mid-period load never shortens or extends the current period.
//  Arithmetic: all compares unsigned WIDTH bits; period-1 never underflows (period>=2).
// TESTING
//  1. enable=0, load div=4 duty=0; then enable=1 -> clock_out 1100 repeating, tick at each first '1', pending 0.
//  2. load div=5 duty=2 while disabled, enable -> clock_out 11000 repeating, tick every 5 cycles.
//  3. Clamps: div=1 -> 1010 repeating; div=5 duty=7 -> 11110 repeating; div=0 duty=0 -> 10 repeating.
//  4. Running div=8 duty=4; load div=4 duty=1 at phase 2 -> pending=1 until wrap; period finishes 11110000, then 1000 repeating.
//  5. enable low at phase 3 -> next edge clock_out=0, tick=0; enable high -> first edge tick=1, clock_out=1.
//  6. reset_n low mid-run with pending=1 -> next edge clock_out=0, tick=0, pending=0; enable resumes with DIV_RESET period.

Source files
------------

// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : prog_clock_divider
//  Description : Runtime-programmable clock divider / tick generator.
//                Divides clock_in by an integer period (2..2^WIDTH-1) with a
//                programmable high time. Produces a registered divided clock
//                and a one-cycle tick on the first cycle of every period.
//                New settings are staged in shadow registers and applied only
//                at a period boundary or while the divider is parked.
//  Revision    : 1.0  initial release
// ============================================================================
module prog_clock_divider #(
  parameter int          WIDTH     = 18,
  parameter int unsigned DIV_RESET = 2**(WIDTH-1)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic             clock_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] c_DIV_RESET  = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] c_HIGH_RESET = c_DIV_RESET >> 1;
  localparam logic [WIDTH-1:0] c_ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_TWO        = WIDTH'(2);

  // Active settings and phase counter
  logic [WIDTH-1:0] r_phase;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high;
  // Staged settings waiting for the next update point
  logic [WIDTH-1:0] r_sh_period;
  logic [WIDTH-1:0] r_sh_high;
  logic             r_pending;
  logic             r_clock_out;
  logic             r_tick;

  logic [WIDTH-1:0] w_ld_period;
  logic [WIDTH-1:0] w_ld_high;
  logic [WIDTH-1:0] w_nxt_period;
  logic [WIDTH-1:0] w_nxt_high;
  logic [WIDTH-1:0] w_phase_inc;
  logic             w_wrap;

  // Clamp requested values and select the settings an update point would apply
  always_comb begin
    w_ld_period = (div_in < c_TWO) ? c_TWO : div_in;
    if (duty_in == '0) begin
      w_ld_high = w_ld_period >> 1;
    end else if (duty_in >= w_ld_period) begin
      w_ld_high = w_ld_period - c_ONE;
    end else begin
      w_ld_high = duty_in;
    end

    // A load coinciding with an update point wins over any older shadow
    if (load) begin
      w_nxt_period = w_ld_period;
      w_nxt_high   = w_ld_high;
    end else if (r_pending) begin
      w_nxt_period = r_sh_period;
      w_nxt_high   = r_sh_high;
    end else begin
      w_nxt_period = r_period;
      w_nxt_high   = r_high;
    end

    w_wrap      = (r_phase == (r_period - c_ONE));
    w_phase_inc = r_phase + c_ONE;
  end

  // Phase counter, setting update and registered outputs
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_phase     <= c_DIV_RESET - c_ONE;
      r_period    <= c_DIV_RESET;
      r_high      <= c_HIGH_RESET;
      r_sh_period <= c_DIV_RESET;
      r_sh_high   <= c_HIGH_RESET;
      r_pending   <= 1'b0;
      r_clock_out <= 1'b0;
      r_tick      <= 1'b0;
    end else if (!enable) begin
      // Parked: take any new setting now and sit one cycle before a wrap,
      // so the first enabled edge starts a fresh period
      r_period    <= w_nxt_period;
      r_high      <= w_nxt_high;
      r_phase     <= w_nxt_period - c_ONE;
      r_pending   <= 1'b0;
      r_clock_out <= 1'b0;
      r_tick      <= 1'b0;
    end else if (w_wrap) begin
      // Period boundary: new high time governs phase 0 directly
      r_period    <= w_nxt_period;
      r_high      <= w_nxt_high;
      r_phase     <= '0;
      r_pending   <= 1'b0;
      r_clock_out <= (w_nxt_high != '0);
      r_tick      <= 1'b1;
    end else begin
      r_phase     <= w_phase_inc;
      r_clock_out <= (w_phase_inc < r_high);
      r_tick      <= 1'b0;
      if (load) begin
        r_sh_period <= w_ld_period;
        r_sh_high   <= w_ld_high;
        r_pending   <= 1'b1;
      end
    end
  end

  assign clock_out = r_clock_out;
  assign tick      = r_tick;
  assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_clock_divider
//  Description : Self-checking bench for prog_clock_divider. The driver
//                queues the hand-computed response for every clock edge; a
//                monitor pops and compares after each edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prog_clock_divider;

  localparam int W = 8;   // DIV_RESET defaults to 128, high time 64

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic         load;
  logic [W-1:0] div_in;
  logic [W-1:0] duty_in;
  logic         clock_out;
  logic         tick;
  logic         pending;

  typedef struct {
    logic            clk;
    logic            tick;
    logic            pend;
    bit [8*12-1:0]   nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   drv_done = 1'b0;

  prog_clock_divider #(.WIDTH(W)) dut (
    .clock_in  (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .load      (load),
    .div_in    (div_in),
    .duty_in   (duty_in),
    .clock_out (clock_out),
    .tick      (tick),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge of stimulus plus its expected post-edge outputs
  task automatic cyc(input logic rn, input logic en, input logic ld,
                     input logic [W-1:0] div, input logic [W-1:0] duty,
                     input logic ec, input logic et, input logic ep,
                     input bit [8*12-1:0] nm);
    exp_t e;
    @(negedge clk);
    reset_n = rn;
    enable  = en;
    load    = ld;
    div_in  = div;
    duty_in = duty;
    e.clk = ec; e.tick = et; e.pend = ep; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
  endtask

  // Free-running enabled edges; pattern starts at a period boundary
  task automatic run_pat(input bit [8*12-1:0] nm, input string pat, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < pat.len(); i++) begin
        cyc(1'b1, 1'b1, 1'b0, '0, '0, (pat[i] == 8'h31), (i == 0), 1'b0, nm);
      end
    end
  endtask

  // Monitor: compare every edge against the queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_checks++;
        if (clock_out === e.clk && tick === e.tick && pending === e.pend) begin
          n_pass++;
        end else begin
          $display("FAIL %0s t=%0t got clk=%b tick=%b pend=%b want clk=%b tick=%b pend=%b",
                   e.nm, $time, clock_out, tick, pending, e.clk, e.tick, e.pend);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; div_in = '0; duty_in = '0;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "reset");
    cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "reset_en");

    // 1: div=4 duty=0 loaded while disabled
    cyc(1'b1, 1'b0, 1'b1, 8'd4, 8'd0, 1'b0, 1'b0, 1'b0, "t1_load");
    run_pat("t1_div4", "1100", 3);

    // 2: div=5 duty=2
    cyc(1'b1, 1'b0, 1'b1, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0, "t2_load");
    run_pat("t2_div5d2", "11000", 3);

    // 3: clamps
    cyc(1'b1, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, "t3a_load");
    run_pat("t3a_div1", "10", 3);
    cyc(1'b1, 1'b0, 1'b1, 8'd5, 8'd7, 1'b0, 1'b0, 1'b0, "t3b_load");
    run_pat("t3b_duty7", "11110", 2);
    cyc(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, "t3c_load");
    run_pat("t3c_div0", "10", 2);

    // 4: mid-period load waits for the wrap
    cyc(1'b1, 1'b0, 1'b1, 8'd8, 8'd4, 1'b0, 1'b0, 1'b0, "t4_load8");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "t4_ph0");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "t4_ph1");
    cyc(1'b1, 1'b1, 1'b1, 8'd4, 8'd1, 1'b1, 1'b0, 1'b1, "t4_ph2_ld");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "t4_ph3");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "t4_ph4");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "t4_ph5");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "t4_ph6");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "t4_ph7");
    run_pat("t4_div4d1", "1000", 3);

    // Load on the wrap edge applies immediately, pending stays low
    cyc(1'b1, 1'b1, 1'b1, 8'd6, 8'd3, 1'b1, 1'b1, 1'b0, "wrap_ld");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "wrap_ph1");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "wrap_ph2");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "wrap_ph3");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "wrap_ph4");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "wrap_ph5");
    run_pat("wrap_div6", "111000", 1);

    // Two mid-period loads: the last one wins
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "lw_ph0");
    cyc(1'b1, 1'b1, 1'b1, 8'd3, 8'd0, 1'b1, 1'b0, 1'b1, "lw_ld1");
    cyc(1'b1, 1'b1, 1'b1, 8'd4, 8'd3, 1'b1, 1'b0, 1'b1, "lw_ld2");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "lw_ph3");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "lw_ph4");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "lw_ph5");
    run_pat("lw_div4d3", "1110", 2);

    // 5: disable mid-period, re-enable restarts the period
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "t5_ph0");
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "t5_ph1");
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "t5_dis");
    run_pat("t5_reen", "1110", 2);

    // 6: reset with a pending setting (and load asserted) discards it
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "t6_ph0");
    cyc(1'b1, 1'b1, 1'b1, 8'd10, 8'd0, 1'b1, 1'b0, 1'b1, "t6_pend");
    cyc(1'b0, 1'b1, 1'b1, 8'd10, 8'd0, 1'b0, 1'b0, 1'b0, "t6_reset");
    for (int i = 0; i < 128; i++) begin
      cyc(1'b1, 1'b1, 1'b0, '0, '0, (i < 64), (i == 0), 1'b0, "t6_div128");
    end
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "t6_wrap2");

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain got %0d entries left want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
